// File: rtl/array_sort_check_pkg.sv
// Shared types and constants for the array sortedness checker.
package arraysort_pkg;

    localparam int unsigned STATE_W = 5;

    // One-hot controller states.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 5'b00001,
        FETCH0 = 5'b00010,
        CMP    = 5'b00100,
        DONE_T = 5'b01000,
        DONE_F = 5'b10000
    } sortState_e;

    // Requested order.
    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

endpackage

// File: rtl/array_sort_check_if.sv
// Control/status and memory read port of the sortedness checker.
// ARRAY_SORT_CHECK_INV_COUNT_EN adds the inversion_count status signal.
interface array_sort_check_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              go;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              descending;
    logic              strict;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              sorted;
    logic [ADDR_W-1:0] first_inversion;
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
    logic [ADDR_W-1:0] inversion_count;

    modport master (
        output go, base_addr, length, descending, strict, rd_data,
        input  rd_addr, rd_en, done, sorted, first_inversion, inversion_count
    );
    modport slave (
        input  go, base_addr, length, descending, strict, rd_data,
        output rd_addr, rd_en, done, sorted, first_inversion, inversion_count
    );
`else
    modport master (
        output go, base_addr, length, descending, strict, rd_data,
        input  rd_addr, rd_en, done, sorted, first_inversion
    );
    modport slave (
        input  go, base_addr, length, descending, strict, rd_data,
        output rd_addr, rd_en, done, sorted, first_inversion
    );
`endif
endinterface

// File: rtl/array_sort_check_order_compare.sv
// Flags whether neighbour pair (a = earlier, b = later) breaks the requested order.
module order_compare
    import arraysort_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              descending,
    input  logic              strict,
    output logic              inversion
);

    logic aGtB;
    logic aEqB;
    logic aLtB;

    // Magnitude relation under the configured signedness, then order selection.
    always_comb begin
        aEqB = (a == b);
        if (SIGNED) begin
            aGtB = ($signed(a) > $signed(b));
        end else begin
            aGtB = (a > b);
        end
        aLtB = !aGtB && !aEqB;
        case (descending)
            ASC:     inversion = aGtB || (aEqB && strict);
            DESC:    inversion = aLtB || (aEqB && strict);
            default: inversion = 1'b0;
        endcase
    end

endmodule

// File: rtl/array_sort_check.sv
// Sortedness checker: walks LENGTH words from base_addr through a combinational
// read port and reports sorted/unsorted plus the first inversion index.
// Build option ARRAY_SORT_CHECK_INV_COUNT_EN: full scan with inversion counting.
module array_sort_check
    import arraysort_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    array_sort_check_if.slave bus
);

    sortState_e        state;
    logic [ADDR_W-1:0] baseQ;
    logic [ADDR_W-1:0] lenQ;
    logic              descQ;
    logic              strictQ;
    logic [DATA_W-1:0] prevQ;
    logic [ADDR_W-1:0] idxQ;
    logic [ADDR_W-1:0] rdAddrQ;
    logic              rdEnQ;
    logic              doneQ;
    logic              sortedQ;
    logic [ADDR_W-1:0] firstInvQ;
    logic              inversion;
    logic              lastIdx;
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
    logic [ADDR_W-1:0] invCountQ;
    logic [ADDR_W-1:0] invCountNext;
`endif

    order_compare #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_order_compare (
        .a          (prevQ),
        .b          (bus.rd_data),
        .descending (descQ),
        .strict     (strictQ),
        .inversion  (inversion)
    );

    assign lastIdx = (idxQ == (lenQ - ADDR_W'(1)));

`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
    // Saturating count including the pair compared this cycle.
    assign invCountNext = (inversion && (invCountQ != '1)) ? (invCountQ + ADDR_W'(1)) : invCountQ;
    assign bus.inversion_count = invCountQ;
`endif

    assign bus.rd_addr         = rdAddrQ;
    assign bus.rd_en           = rdEnQ;
    assign bus.done            = doneQ;
    assign bus.sorted          = sortedQ;
    assign bus.first_inversion = firstInvQ;

    // Control FSM with registered read strobe, address and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            baseQ     <= '0;
            lenQ      <= '0;
            descQ     <= 1'b0;
            strictQ   <= 1'b0;
            prevQ     <= '0;
            idxQ      <= '0;
            rdAddrQ   <= '0;
            rdEnQ     <= 1'b0;
            doneQ     <= 1'b0;
            sortedQ   <= 1'b0;
            firstInvQ <= '0;
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
            invCountQ <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    baseQ   <= bus.base_addr;
                    lenQ    <= bus.length;
                    descQ   <= bus.descending;
                    strictQ <= bus.strict;
                    if (bus.go) begin
                        firstInvQ <= '0;
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
                        invCountQ <= '0;
`endif
                        if (bus.length <= ADDR_W'(1)) begin
                            // Empty or single-element arrays are trivially ordered.
                            state   <= DONE_T;
                            doneQ   <= 1'b1;
                            sortedQ <= 1'b1;
                        end else begin
                            state   <= FETCH0;
                            sortedQ <= 1'b0;
                            rdEnQ   <= 1'b1;
                            rdAddrQ <= bus.base_addr;
                        end
                    end
                end

                FETCH0: begin
                    prevQ   <= bus.rd_data;
                    idxQ    <= ADDR_W'(1);
                    rdAddrQ <= baseQ + ADDR_W'(1);
                    state   <= CMP;
                end

                CMP: begin
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
                    // Full scan: record the earliest inversion, count them all.
                    if (inversion && (firstInvQ == '0)) begin
                        firstInvQ <= idxQ;
                    end
                    invCountQ <= invCountNext;
                    if (lastIdx) begin
                        rdEnQ   <= 1'b0;
                        doneQ   <= 1'b1;
                        sortedQ <= (invCountNext == '0);
                        state   <= (invCountNext == '0) ? DONE_T : DONE_F;
                    end else begin
                        prevQ   <= bus.rd_data;
                        idxQ    <= idxQ + ADDR_W'(1);
                        rdAddrQ <= baseQ + idxQ + ADDR_W'(1);
                    end
`else
                    // Early exit at the first inversion.
                    if (inversion) begin
                        rdEnQ     <= 1'b0;
                        doneQ     <= 1'b1;
                        sortedQ   <= 1'b0;
                        firstInvQ <= idxQ;
                        state     <= DONE_F;
                    end else if (lastIdx) begin
                        rdEnQ   <= 1'b0;
                        doneQ   <= 1'b1;
                        sortedQ <= 1'b1;
                        state   <= DONE_T;
                    end else begin
                        prevQ   <= bus.rd_data;
                        idxQ    <= idxQ + ADDR_W'(1);
                        rdAddrQ <= baseQ + idxQ + ADDR_W'(1);
                    end
`endif
                end

                DONE_T, DONE_F: begin
                    if (bus.go) begin
                        doneQ <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    rdEnQ <= 1'b0;
                    doneQ <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_sort_check.sv
// Self-checking bench: an unsigned and a signed checker share one memory and
// stimulus; each is compared against a behavioural order model.
module tb_array_sort_check;

    localparam int BUDGET = 400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       goIn = 1'b0;
    logic [7:0] baseIn = 8'h00;
    logic [7:0] lenIn = 8'h00;
    logic       descIn = 1'b0;
    logic       strictIn = 1'b0;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    array_sort_check_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
    array_sort_check_if #(.DATA_W(8), .ADDR_W(8)) if1 ();

    assign if0.go = goIn;         assign if1.go = goIn;
    assign if0.base_addr = baseIn; assign if1.base_addr = baseIn;
    assign if0.length = lenIn;     assign if1.length = lenIn;
    assign if0.descending = descIn; assign if1.descending = descIn;
    assign if0.strict = strictIn;  assign if1.strict = strictIn;
    assign if0.rd_data = mem[if0.rd_addr];
    assign if1.rd_data = mem[if1.rd_addr];

    array_sort_check #(.DATA_W(8), .ADDR_W(8), .SIGNED(1'b0)) dut0 (
        .clock (clock), .reset (reset), .bus (if0));
    array_sort_check #(.DATA_W(8), .ADDR_W(8), .SIGNED(1'b1)) dut1 (
        .clock (clock), .reset (reset), .bus (if1));

    logic       doneV [2];
    logic       sortedV [2];
    logic       rdEnV [2];
    logic [7:0] rdAddrV [2];
    logic [7:0] firstV [2];
    assign doneV[0] = if0.done;   assign doneV[1] = if1.done;
    assign sortedV[0] = if0.sorted; assign sortedV[1] = if1.sorted;
    assign rdEnV[0] = if0.rd_en;  assign rdEnV[1] = if1.rd_en;
    assign rdAddrV[0] = if0.rd_addr; assign rdAddrV[1] = if1.rd_addr;
    assign firstV[0] = if0.first_inversion; assign firstV[1] = if1.first_inversion;
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
    logic [7:0] countV [2];
    assign countV[0] = if0.inversion_count; assign countV[1] = if1.inversion_count;
`endif

    // Reference: walk neighbour pairs with integer arithmetic.
    function automatic void model(input int sg, input logic [7:0] b, input logic [7:0] l,
                                  input logic d, input logic s, output bit srt,
                                  output int fi, output int cnt, output int lat);
        int a, c;
        bit bad;
        fi = 0;
        cnt = 0;
        for (int i = 1; i < int'(l); i++) begin
            a = sg ? int'($signed(mem[(int'(b) + i - 1) % 256])) : int'(mem[(int'(b) + i - 1) % 256]);
            c = sg ? int'($signed(mem[(int'(b) + i) % 256])) : int'(mem[(int'(b) + i) % 256]);
            if (d) bad = s ? (a <= c) : (a < c);
            else   bad = s ? (a >= c) : (a > c);
            if (bad) begin
                if (fi == 0) fi = i;
                if (cnt < 255) cnt++;
            end
        end
        srt = (fi == 0);
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
        lat = (l <= 1) ? 0 : int'(l);
`else
        lat = (l <= 1) ? 0 : ((fi != 0) ? fi + 1 : int'(l));
`endif
    endfunction

    // One go/done transaction on both checkers, then acknowledge.
    task automatic runScan(input string name, input logic [7:0] b, input logic [7:0] l,
                           input logic d, input logic s);
        bit expSorted [2];
        int expFirst [2], expCount [2], expLat [2];
        bit got [2];
        int lat [2], reads [2];
        for (int u = 0; u < 2; u++) begin
            model(u, b, l, d, s, expSorted[u], expFirst[u], expCount[u], expLat[u]);
            got[u] = 1'b0; lat[u] = -1; reads[u] = 0;
        end
        @(negedge clock);
        baseIn = b; lenIn = l; descIn = d; strictIn = s; goIn = 1'b1;
        @(posedge clock);
        for (int n = 0; n <= BUDGET; n++) begin
            @(negedge clock);
            goIn = 1'b0;
            for (int u = 0; u < 2; u++) begin
                if (!got[u]) begin
                    if (doneV[u]) begin
                        got[u] = 1'b1; lat[u] = n;
                    end else if (rdEnV[u]) begin
                        checks++;
                        if (rdAddrV[u] !== 8'(int'(b) + reads[u])) begin
                            errors++;
                            $display("FAIL %s dut%0d rd_addr[%0d] got %h expected %h", name, u,
                                     reads[u], rdAddrV[u], 8'(int'(b) + reads[u]));
                        end
                        reads[u]++;
                    end
                end
            end
            if (got[0] && got[1]) break;
            @(posedge clock);
        end
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (lat[u] !== expLat[u]) begin
                errors++;
                $display("FAIL %s dut%0d latency got %0d expected %0d", name, u, lat[u], expLat[u]);
            end
            checks++;
            if (reads[u] !== expLat[u]) begin
                errors++;
                $display("FAIL %s dut%0d read cycles got %0d expected %0d", name, u, reads[u], expLat[u]);
            end
            checks++;
            if (sortedV[u] !== expSorted[u]) begin
                errors++;
                $display("FAIL %s dut%0d sorted got %b expected %b", name, u, sortedV[u], expSorted[u]);
            end
            checks++;
            if (firstV[u] !== 8'(expFirst[u])) begin
                errors++;
                $display("FAIL %s dut%0d first_inversion got %0d expected %0d", name, u, firstV[u], expFirst[u]);
            end
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
            checks++;
            if (countV[u] !== 8'(expCount[u])) begin
                errors++;
                $display("FAIL %s dut%0d inversion_count got %0d expected %0d", name, u, countV[u], expCount[u]);
            end
`endif
        end
        @(negedge clock); goIn = 1'b1;
        @(posedge clock);
        @(negedge clock); goIn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (doneV[u] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d done after ack got %b expected 0", name, u, doneV[u]);
            end
        end
    endtask

    task automatic checkResetState(input string name);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({doneV[u], sortedV[u], rdEnV[u], rdAddrV[u], firstV[u]} !== 19'd0) begin
                errors++;
                $display("FAIL %s dut%0d outputs got done=%b sorted=%b rd_en=%b rd_addr=%h first=%h expected all 0",
                         name, u, doneV[u], sortedV[u], rdEnV[u], rdAddrV[u], firstV[u]);
            end
`ifdef ARRAY_SORT_CHECK_INV_COUNT_EN
            checks++;
            if (countV[u] !== 8'd0) begin
                errors++;
                $display("FAIL %s dut%0d inversion_count got %0d expected 0", name, u, countV[u]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkResetState("reset");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd2; mem[8'h13] = 8'd7; mem[8'h14] = 8'd9;
        runScan("asc_nonstrict", 8'h10, 8'd5, 1'b0, 1'b0);
        runScan("asc_strict", 8'h10, 8'd5, 1'b0, 1'b1);
    endtask

    task automatic test_descending();
        mem[8'h20] = 8'd9; mem[8'h21] = 8'd4; mem[8'h22] = 8'd4; mem[8'h23] = 8'd0;
        runScan("desc", 8'h20, 8'd4, 1'b1, 1'b0);
        runScan("desc_as_asc", 8'h20, 8'd4, 1'b0, 1'b0);
        mem[8'h28] = 8'd3; mem[8'h29] = 8'd1; mem[8'h2A] = 8'd2; mem[8'h2B] = 8'd0;
        runScan("multi_inv", 8'h28, 8'd4, 1'b0, 1'b0);
    endtask

    task automatic test_signed();
        mem[8'h30] = 8'h80; mem[8'h31] = 8'hFF; mem[8'h32] = 8'h01;
        runScan("signedness", 8'h30, 8'd3, 1'b0, 1'b0);
    endtask

    task automatic test_boundaries();
        runScan("len0", 8'h30, 8'd0, 1'b0, 1'b1);
        runScan("len1", 8'h30, 8'd1, 1'b1, 1'b1);
        mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd5; mem[8'h00] = 8'd6; mem[8'h01] = 8'd8;
        runScan("wrap", 8'hFE, 8'd4, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] b, l, v;
        logic d, s;
        for (int t = 0; t < 25; t++) begin
            b = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 24));
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            v = 8'($urandom);
            for (int i = 0; i < int'(l); i++) begin
                mem[(int'(b) + i) % 256] = v;
                if (d) v = v - 8'($urandom_range(0, 2));
                else   v = v + 8'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) v = 8'($urandom);
            end
            runScan("random", b, l, d, s);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 10; i++) mem[8'h40 + i] = 8'(i * 3);
        @(negedge clock);
        baseIn = 8'h40; lenIn = 8'd10; descIn = 1'b0; strictIn = 1'b0; goIn = 1'b1;
        @(posedge clock);
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            goIn = 1'b0;
            if (rdEnV[0] && rdAddrV[0] == 8'h43) begin found = 1'b1; break; end
            @(posedge clock);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid reached idx 3 got 0 expected 1");
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkResetState("reset_mid_scan");
        @(posedge clock);
        @(negedge clock);
        checkResetState("idle_after_reset");
        mem[8'h48] = 8'd5; mem[8'h49] = 8'd1;
        baseIn = 8'h48; lenIn = 8'd2; goIn = 1'b1;
        @(posedge clock);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            goIn = 1'b0;
            if (doneV[0]) begin found = 1'b1; break; end
            @(posedge clock);
        end
        checks++;
        if (!found || firstV[0] !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_done setup got done=%b first=%0d expected done=1 first=1", found, firstV[0]);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkResetState("reset_mid_done");
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        mem[8'h50] = 8'd1; mem[8'h51] = 8'd2; mem[8'h52] = 8'd3;
        mem[8'h60] = 8'd4; mem[8'h61] = 8'd5; mem[8'h62] = 8'd6;
        @(negedge clock);
        baseIn = 8'h50; lenIn = 8'd3; descIn = 1'b0; strictIn = 1'b1; goIn = 1'b1;
        @(posedge clock);
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (doneV[0]) begin found = 1'b1; break; end
            @(posedge clock);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b first run done got 0 expected 1");
        end
        baseIn = 8'h60;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (doneV[0] !== 1'b0 || rdEnV[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle cycle got done=%b rd_en=%b expected 0 0", doneV[0], rdEnV[0]);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (rdEnV[0] !== 1'b1 || rdAddrV[0] !== 8'h60) begin
            errors++;
            $display("FAIL b2b restart got rd_en=%b rd_addr=%h expected 1 60", rdEnV[0], rdAddrV[0]);
        end
        @(posedge clock);
        @(negedge clock);
        goIn = 1'b0;
        checks++;
        if (doneV[0] !== 1'b0 || rdAddrV[0] !== 8'h61) begin
            errors++;
            $display("FAIL b2b go ignored in scan got done=%b rd_addr=%h expected 0 61", doneV[0], rdAddrV[0]);
        end
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (doneV[0]) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || sortedV[0] !== 1'b1 || sortedV[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b second run got done=%b sorted=%b/%b expected 1 1/1", found, sortedV[0], sortedV[1]);
        end
        goIn = 1'b1;
        @(posedge clock);
        @(negedge clock);
        goIn = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_descending();
        test_signed();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/array_sort_check.md
Name: array_sort_check

Overview:
- Self-contained sortedness checker: control FSM plus datapath in one block.
- Scans LENGTH words of an external array memory through a combinational read port and reports sorted/unsorted and the index of the first inversion.
- Generalised over data width, address width, signedness, runtime sort direction and strict/non-strict ordering.
- Sits between the lab top level and the array memory; software pulses go and polls done.

Parameters:
- DATA_W, 32, element width in bits.
- ADDR_W, 8, address/index/length width.
- SIGNED, 0, 1 compares elements as two's complement, 0 as unsigned.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; forces IDLE.
- go  in  1  start request; also acknowledges a finished result.
- base_addr  in  ADDR_W  address of element 0.
- length  in  ADDR_W  element count.
- descending  in  1  0 checks non-decreasing order, 1 checks non-increasing order.
- strict  in  1  1 makes equal neighbours count as an inversion.
- rd_addr  out  ADDR_W  memory read address.
- rd_en  out  1  read strobe.
- rd_data  in  DATA_W  memory data, valid in the same cycle as rd_addr.
- done  out  1  result valid.
- sorted  out  1  array satisfies the requested order; meaningful only while done=1.
- first_inversion  out  ADDR_W  index i (1..length-1) where element[i-1] and element[i] violate the order; 0 if sorted.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE; done=0, sorted=0, first_inversion=0, rd_en=0, rd_addr=0.
- States:
  - IDLE: latches base_addr, length, descending and strict every cycle.
    - go=1 with length<=1 -> DONE_T.
    - go=1 otherwise -> FETCH0.
    - go=0 stays IDLE.
  - FETCH0: rd_en=1, rd_addr=base; prev<=rd_data; idx<=1 -> CMP.
  - CMP: rd_en=1, rd_addr=base+idx.
    - inversion(prev,rd_data) -> DONE_F, first_inversion<=idx.
    - else if idx==length-1 -> DONE_T.
    - else prev<=rd_data, idx<=idx+1, stay.
  - DONE_T: done=1, sorted=1. go=1 -> IDLE, else hold.
  - DONE_F: done=1, sorted=0. go=1 -> IDLE, else hold.
- Inversion rule: for ascending, prev>cur, or prev>=cur when strict. Descending mirrors it. Signedness per SIGNED.
- Latency: with go sampled at edge k and length N>=2, done rises after edge k+N on a sorted array. On an inversion at index i, done rises after edge k+i+1. With length<=1, done rises after edge k.
- Addresses: base+idx wraps modulo 2^ADDR_W. length is unsigned, so length=2^ADDR_W-1 is legal.
- go while in FETCH0 or CMP is ignored.
- go held high across DONE -> IDLE -> restart: a new run begins one cycle after IDLE, using inputs latched in that IDLE cycle.
- Reset mid-scan or mid-done: IDLE on the next edge; all outputs return to reset values.
- first_inversion and sorted hold until IDLE is re-entered; they are cleared on entry to FETCH0.
- rd_en=0 in IDLE and DONE states; rd_addr is don't-care when rd_en=0.

Optional Feature:
- Macro: ARRAY_SORT_CHECK_INV_COUNT_EN.
- Defined:
  - CMP does not exit on an inversion; it scans to idx==length-1.
  - Adds output inversion_count [ADDR_W], saturating at all-ones.
  - sorted = (inversion_count==0) in the DONE state.
  - first_inversion still records the earliest inversion.
  - Latency is always N cycles for N>=2.
  - inversion_count resets to 0 and clears on entry to FETCH0.
- Undefined: early exit as specified above; the inversion_count port is absent.

Decomposition:
- Package arraysort_pkg:
  - state encoding constants IDLE, FETCH0, CMP, DONE_T, DONE_F (one-hot, 5 bits).
  - direction constants ASC=0, DESC=1.
- One combinational sub-module, order_compare:
  - parameters DATA_W, SIGNED.
  - inputs a, b, descending, strict; output inversion.
- FSM and counters live in array_sort_check.

Test Plan:
- DATA_W=8, base=0x10, length=5, array {1,2,2,7,9}, asc, strict=0 -> done after 5 cycles, sorted=1, first_inversion=0; rd_addr sequence 0x10..0x14.
- Same array with strict=1 -> DONE_F after 3 cycles, first_inversion=2.
- {9,4,4,0} descending, non-strict -> sorted=1. Same array ascending -> sorted=0, first_inversion=1, done after 2 cycles.
- SIGNED=1, {0x80,0xFF,0x01} asc -> sorted=1. SIGNED=0, same array -> first_inversion=2.
- length=0 and length=1 -> done one edge after go, sorted=1, rd_en never high. base=0xFE, length=4 -> rd_addr 0xFE,0xFF,0x00,0x01.
- Reset asserted in CMP at idx=3 -> IDLE and done=0 next edge. go held high through done -> IDLE one cycle, then restart. With ARRAY_SORT_CHECK_INV_COUNT_EN, {3,1,2,0} asc -> inversion_count=2, first_inversion=1, done after 4 cycles.
